// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the streaming average-pool engine.
package pool_pkg;

  localparam int POOL_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } pool_state_t;

  // Sum of WIN signed DATA_W-bit values needs log2(WIN) guard bits.
  function automatic int acc_width(input int data_w, input int win);
    return data_w + $clog2(win);
  endfunction

endpackage

// File: rtl/pool_acc.sv
// Single-channel window accumulator with the averaging output register.
// Optional macro POOL_ROUND_EN selects round-half-up instead of floor.
module pool_acc
  import pool_pkg::*;
#(
  parameter int DATA_W = POOL_DATA_W,
  parameter int WIN    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_i,
  input  logic                     add_i,
  input  logic                     fin_i,
  input  logic signed [DATA_W-1:0] din_i,
  output logic signed [DATA_W-1:0] dout_o
);

  localparam int CNT_W = $clog2(WIN);
  localparam int ACC_W = acc_width(DATA_W, WIN);

`ifdef POOL_ROUND_EN
  localparam int                    RND_I = 1 << (CNT_W - 1);
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(RND_I);
`endif

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  din_ext, sum;
  logic signed [DATA_W-1:0] dout_q, dout_d;

  // Divide by WIN; the result always fits DATA_W, so plain truncation is exact.
  function automatic logic signed [DATA_W-1:0] avg_round(input logic signed [ACC_W-1:0] total);
    logic signed [ACC_W-1:0] biased;
`ifdef POOL_ROUND_EN
    biased = total + RND;
`else
    biased = total;
`endif
    return DATA_W'(biased >>> CNT_W);
  endfunction

  assign din_ext = {{CNT_W{din_i[DATA_W-1]}}, din_i};
  assign sum     = acc_q + din_ext;

  always_comb begin
    acc_d  = acc_q;
    dout_d = dout_q;
    if (ld_i) begin
      acc_d = din_ext;
    end else if (add_i) begin
      acc_d = sum;
    end
    if (fin_i) begin
      dout_d = avg_round(sum);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      dout_q <= '0;
    end else begin
      acc_q  <= acc_d;
      dout_q <= dout_d;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/pool_array.sv
// Multi-channel streaming average-pool engine with valid/ready on both sides.
// Optional macro POOL_ROUND_EN (in pool_acc) rounds half up instead of flooring.
module pool_array
  import pool_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = POOL_DATA_W,
  parameter int WIN    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data  [0:NUM_CH-1],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data [0:NUM_CH-1],
  output logic                     busy
);

  localparam int               CNT_W    = $clog2(WIN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);

  pool_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q;
  logic             accept, ld, add, fin;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld      = 1'b0;
    add     = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ld      = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          add   = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            fin     = 1'b1;
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready is registered so it stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= (state_d != OUT);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pool_acc #(
      .DATA_W(DATA_W),
      .WIN   (WIN)
    ) u_acc (
      .clk   (clk),
      .rst   (rst),
      .ld_i  (ld),
      .add_i (add),
      .fin_i (fin),
      .din_i (in_data[c]),
      .dout_o(out_data[c])
    );
  end

endmodule

// File: tb/tb_pool_array.sv
// Directed bench for pool_array: default 2ch/WIN=64 instance plus a 4ch/WIN=4 instance.
module tb_pool_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic               in_valid, in_ready, out_valid, out_ready, busy;
  logic signed [15:0] in_data  [0:1];
  logic signed [15:0] out_data [0:1];

  logic               s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic signed [15:0] s_in_data  [0:3];
  logic signed [15:0] s_out_data [0:3];

  int err_cnt = 0;
  int chk_cnt = 0;

  pool_array u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  pool_array #(.NUM_CH(4), .DATA_W(16), .WIN(4)) u_small (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .in_data  (s_in_data),
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .out_data (s_out_data),
    .busy     (s_busy)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; idles for gap cycles, then holds one beat until accepted.
  task automatic push(input logic [15:0] d0, input logic [15:0] d1, input int gap);
    bit ok;
    ok = 1'b0;
    for (int g = 0; g < gap; g++) begin
      in_valid   = 1'b0;
      in_data[0] = 16'h7FFF;
      in_data[1] = 16'h7FFF;
      @(negedge clk);
    end
    in_data[0] = d0;
    in_data[1] = d1;
    in_valid   = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      ok = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) check("push_timeout", 16'(ok), 16'd1);
  endtask

  task automatic wait_ov(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 16'(out_valid), 16'd1);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_ov_drop"}, 16'(out_valid), 16'd0);
    check({tag, "_idle"}, 16'(busy), 16'd0);
  endtask

  initial begin
    logic [15:0] exp0, exp1, hold0, hold1;

    rst         = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_data     = '{16'h0, 16'h0};
    s_in_valid  = 1'b0;
    s_out_ready = 1'b0;
    s_in_data   = '{16'h0, 16'h0, 16'h0, 16'h0};

    // Reset state
    #2;
    @(negedge clk);
    check("rst_in_ready", 16'(in_ready), 16'd0);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_out0", out_data[0], 16'h0);
    check("rst_s_in_ready", 16'(s_in_ready), 16'd0);
    rst = 1'b1;
    #1;
    check("rel_in_ready_pre", 16'(in_ready), 16'd0);
    @(negedge clk);
    check("rel_in_ready_post", 16'(in_ready), 16'd1);

    // Constant window, back-to-back, out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      push(16'h0100, 16'hFF00, 0);
      if (i == 0)  check("t1_busy_first", 16'(busy), 16'd1);
      if (i == 62) check("t1_ov_early", 16'(out_valid), 16'd0);
    end
    check("t1_ov_latency", 16'(out_valid), 16'd1);
    check("t1_out0", out_data[0], 16'h0100);
    check("t1_out1", out_data[1], 16'hFF00);
    check("t1_in_ready_low", 16'(in_ready), 16'd0);
    @(negedge clk);
    check("t1_ov_drop", 16'(out_valid), 16'd0);
    check("t1_in_ready_back", 16'(in_ready), 16'd1);
    check("t1_busy_low", 16'(busy), 16'd0);

    // Ramp: sum 2016 -> 31.5; ch1 all -1
    for (int i = 0; i < 64; i++) push(16'(i), 16'hFFFF, 0);
    wait_ov("t2_ov");
`ifdef POOL_ROUND_EN
    exp0 = 16'd32;
`else
    exp0 = 16'd31;
`endif
    check("t2_ramp_out0", out_data[0], exp0);
    check("t2_neg1_out1", out_data[1], 16'hFFFF);
    handshake("t2");

    // Gaps + backpressure: ch0 sum 96 (1.5), ch1 sum -32 (-0.5)
    out_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      push((i % 2 == 0) ? 16'd3 : 16'd0, (i % 2 == 0) ? 16'hFFFF : 16'h0000,
           int'($urandom_range(0, 2)));
      if (i == 20) check("t3_busy_gap", 16'(busy), 16'd1);
    end
    wait_ov("t3_ov");
`ifdef POOL_ROUND_EN
    exp0 = 16'd2;
    exp1 = 16'h0000;
`else
    exp0 = 16'd1;
    exp1 = 16'hFFFF;
`endif
    check("t3_out0", out_data[0], exp0);
    check("t3_out1", out_data[1], exp1);
    hold0 = out_data[0];
    hold1 = out_data[1];
    in_valid   = 1'b1;
    in_data[0] = 16'h1111;
    in_data[1] = 16'h2222;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t3_bp_in_ready", 16'(in_ready), 16'd0);
      check("t3_bp_ov", 16'(out_valid), 16'd1);
      check("t3_bp_out0", out_data[0], hold0);
      check("t3_bp_out1", out_data[1], hold1);
    end
    in_valid = 1'b0;
    handshake("t3");
    for (int i = 0; i < 64; i++) push(16'h0010, 16'hFFF0, 0);
    wait_ov("t3b_ov");
    check("t3b_out0", out_data[0], 16'h0010);
    check("t3b_out1", out_data[1], 16'hFFF0);
    handshake("t3b");

    // Extremes
    for (int i = 0; i < 64; i++) push(16'h8000, 16'h7FFF, 0);
    wait_ov("t4_ov");
    check("t4_min_out0", out_data[0], 16'h8000);
    check("t4_max_out1", out_data[1], 16'h7FFF);
    handshake("t4");

    // Reset mid-window
    for (int i = 0; i < 30; i++) push(16'h1234, 16'h1234, 0);
    rst = 1'b0;
    #1;
    check("t5_rst_in_ready", 16'(in_ready), 16'd0);
    check("t5_rst_ov", 16'(out_valid), 16'd0);
    check("t5_rst_busy", 16'(busy), 16'd0);
    check("t5_rst_out0", out_data[0], 16'h0);
    check("t5_rst_out1", out_data[1], 16'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rel_in_ready", 16'(in_ready), 16'd1);
    for (int i = 0; i < 64; i++) push(16'h0004, 16'h0004, 0);
    wait_ov("t5_ov");
    check("t5_out0", out_data[0], 16'h0004);
    check("t5_out1", out_data[1], 16'h0004);
    handshake("t5");

    // Small instance: 4 channels, WIN=4, channel c constant c*3
    s_in_data   = '{16'd0, 16'd3, 16'd6, 16'd9};
    s_out_ready = 1'b0;
    check("t6_busy_idle", 16'(s_busy), 16'd0);
    s_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t6_in_ready", 16'(s_in_ready), 16'd1);
      @(negedge clk);
      check("t6_busy", 16'(s_busy), 16'd1);
    end
    s_in_valid = 1'b0;
    check("t6_ov", 16'(s_out_valid), 16'd1);
    for (int c = 0; c < 4; c++) check($sformatf("t6_out%0d", c), s_out_data[c], 16'(c * 3));
    @(negedge clk);
    check("t6_ov_hold", 16'(s_out_valid), 16'd1);
    check("t6_busy_hold", 16'(s_busy), 16'd1);
    s_out_ready = 1'b1;
    @(negedge clk);
    check("t6_ov_drop", 16'(s_out_valid), 16'd0);
    check("t6_busy_drop", 16'(s_busy), 16'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
